serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller built around a single
// one-bit full adder (fulladder2). Operands are captured on an accepted
// start, summed LSB first over WIDTH cycles, and the result is published
// together with the carry-out and two's-complement overflow flag.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, adds the 'sub' input; sub=1 at start computes a - b as
//   a + ~b + 1 (cin is ignored, cout=1 means no borrow).
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset
//   start     in   request a new operation (sampled only in IDLE)
//   a, b      in   WIDTH-bit operands, captured on accepted start
//   cin       in   carry-in, captured on accepted start
//   sub       in   subtract request (only with SERIAL_ADD_SUB_EN)
//   busy      out  high while bits are being shifted through the adder
//   done      out  one-cycle pulse when sum/cout/overflow become valid
//   sum       out  WIDTH-bit result, held until the next result
//   cout      out  carry out of the MSB
//   overflow  out  carry into MSB XOR carry out of MSB

// Single-bit full adder shared by the serial datapath.
module fulladder2 (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   aReg_q, aReg_d;
    logic [WIDTH-1:0]   bReg_q, bReg_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               faSum;
    logic               faCout;

    // The only adder in the block: one bit per SHIFT cycle.
    fulladder2 uAdder (
        .a_i    (aReg_q[0]),
        .b_i    (bReg_q[0]),
        .cin_i  (carry_q),
        .sum_o  (faSum),
        .cout_o (faCout)
    );

    // State register and datapath flops; reset aborts any operation and
    // clears every visible output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            aReg_q   <= '0;
            bReg_q   <= '0;
            carry_q  <= 1'b0;
            bitCnt_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aReg_q   <= aReg_d;
            bReg_q   <= bReg_d;
            carry_q  <= carry_d;
            bitCnt_q <= bitCnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and datapath logic. The a register doubles as the result
    // shift register: each sum bit enters at the MSB as a[0] leaves at the
    // LSB, so after WIDTH shifts it holds the complete sum. The published
    // outputs only change on the final shift, so partial sums never leak.
    always_comb begin
        state_d  = state_q;
        aReg_d   = aReg_q;
        bReg_d   = bReg_q;
        carry_d  = carry_q;
        bitCnt_d = bitCnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    aReg_d   = a;
                    bReg_d   = b;
                    carry_d  = cin;
                    bitCnt_d = '0;
`ifdef SERIAL_ADD_SUB_EN
                    // a - b is formed as a + ~b + 1.
                    if (sub) begin
                        bReg_d  = ~b;
                        carry_d = 1'b1;
                    end
`endif
                end
            end

            SHIFT: begin
                aReg_d   = {faSum, aReg_q[WIDTH-1:1]};
                bReg_d   = {1'b0, bReg_q[WIDTH-1:1]};
                carry_d  = faCout;
                bitCnt_d = bitCnt_q + CNT_W'(1);
                if (bitCnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this last bit.
                    state_d  = DONE;
                    bitCnt_d = '0;
                    sum_d    = {faSum, aReg_q[WIDTH-1:1]};
                    cout_d   = faCout;
                    ovf_d    = carry_q ^ faCout;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
